spi_frame_ctrl: RTL and testbench

Clock-domain SPI frame sequencer between the motor controller's external SPI pins and its internal register file. Oversamples sclk/ss/mosi on the system clock, decodes the 16-bit frame ({rw, addr[3:0], 3'b000} then data), and issues single-cycle register write or read strobes. For reads it returns the register contents on miso during the second byte. It replaces direct sclk-clocked shift logic, so the config, hardware-ID, watchdog-divisor and watchdog registers (0x2, 0xd, 0xe, 0xf) are all accessed synchronously to clk.

---
 rtl/spi_frame_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_spi_frame_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: system-clock SPI frame sequencer.
// Oversamples the external SPI pins on clk and decodes 16-bit frames of the form
// {rw, addr[3:0], 3'bxxx} followed by a data byte. Each frame issues a single-cycle
// register write or read strobe. On a read, the register contents are returned
// on miso during the second byte.
module spi_frame_ctrl (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sclk,
    input  logic       ss,
    input  logic       mosi,
    output logic       miso,
    output logic       spioe,
    output logic [3:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        FETCH,
        DATA,
        DONE
    } state_e;

    // Synchronizer and edge-detect stages for the asynchronous pins
    logic ssS1_q, ssS2_q;
    logic sclkS1_q, sclkS2_q, sclkS3_q;
    logic mosiS1_q, mosiS2_q, mosiS3_q;
    logic rise_q, fall_q;

    // Frame sequencer state
    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  tx_q, tx_d;
    logic        rw_q, rw_d;
    logic [3:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        miso_q, miso_d;
    logic        we_q, we_d;
    logic        rd_q, rd_d;
    logic [7:0]  shIn;

    // Two-flop synchronizers for ss, sclk and mosi, with an extra stage on each of
    // sclk and mosi. The extra mosi stage makes the data bit line up with the
    // registered rise pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ssS1_q   <= 1'b0;
            ssS2_q   <= 1'b0;
            sclkS1_q <= 1'b0;
            sclkS2_q <= 1'b0;
            sclkS3_q <= 1'b0;
            mosiS1_q <= 1'b0;
            mosiS2_q <= 1'b0;
            mosiS3_q <= 1'b0;
        end else begin
            ssS1_q   <= ss;
            ssS2_q   <= ssS1_q;
            sclkS1_q <= sclk;
            sclkS2_q <= sclkS1_q;
            sclkS3_q <= sclkS2_q;
            mosiS1_q <= mosi;
            mosiS2_q <= mosiS1_q;
            mosiS3_q <= mosiS2_q;
        end
    end

    // Registered single-cycle rise/fall pulses, three clk cycles after the pin edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= sclkS2_q & ~sclkS3_q;
            fall_q <= ~sclkS2_q & sclkS3_q;
        end
    end

    // State and datapath registers of the frame sequencer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            sh_q    <= 8'h00;
            tx_q    <= 8'h00;
            rw_q    <= 1'b0;
            addr_q  <= 4'h0;
            wdata_q <= 8'h00;
            miso_q  <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            miso_q  <= miso_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
        end
    end

    // Next-state logic. A dropped ss takes priority over everything, so an edge
    // arriving in the same cycle as the abort is discarded.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        miso_d  = miso_q;
        we_d    = 1'b0;
        rd_d    = 1'b0;
        shIn    = {sh_q[6:0], mosiS3_q};

        if (!ssS2_q) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = 5'd0;
                    sh_d    = 8'h00;
                    tx_d    = 8'h00;
                    rw_d    = 1'b0;
                    miso_d  = 1'b0;
                    state_d = CMD;
                end
                CMD: begin
                    if (rise_q) begin
                        sh_d  = shIn;
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            rw_d   = shIn[7];
                            addr_d = shIn[6:3];
                            if (shIn[7]) begin
                                rd_d    = 1'b1;
                                state_d = FETCH;
                            end else begin
                                state_d = DATA;
                            end
                        end
                    end
                end
                FETCH: begin
                    // The first FETCH cycle carries the read strobe. The register
                    // file answers one cycle later, and the data is captured then.
                    if (!rd_q) begin
                        tx_d    = reg_rdata;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (rise_q) begin
                        sh_d  = shIn;
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd15) begin
                            state_d = DONE;
                            if (!rw_q) begin
                                we_d    = 1'b1;
                                wdata_d = shIn;
                            end
                        end
                    end
                    if (fall_q && rw_q) begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign miso      = miso_q;
    assign spioe     = rw_q & ssS2_q & ((state_q == DATA) || (state_q == DONE));
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_rd    = rd_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb_spi_frame_ctrl: a bit-level SPI master drives spi_frame_ctrl against a small
// register-file model. Results are compared with a frame-level reference model.
module tb_spi_frame_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       sclk;
    logic       ss;
    logic       mosi;
    logic       miso;
    logic       spioe;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_rd;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;
    logic       misoPad;

    int checks = 0;
    int errors = 0;

    logic [7:0] regMem [16];
    logic [7:0] expMem [16];
    logic       preload = 1'b0;
    logic [3:0] preAddr = 4'h0;
    logic [7:0] preData = 8'h00;

    int         weCount = 0;
    int         rdCount = 0;
    logic [3:0] weAddr = 4'h0;
    logic [7:0] weData = 8'h00;
    logic [3:0] rdAddr = 4'h0;
    int         byteIdx = 0;
    bit         spioeB1 = 1'b0;
    bit         spioeB2 = 1'b0;
    bit         spioeOut = 1'b0;

    spi_frame_ctrl dut (
        .clk       (clk),
        .rstn      (rstn),
        .sclk      (sclk),
        .ss        (ss),
        .mosi      (mosi),
        .miso      (miso),
        .spioe     (spioe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // The miso pad has an external pull-up, so the master reads 1 while the pin is undriven
    assign misoPad = spioe ? miso : 1'b1;

    // Register file: one-cycle read latency, writes on the strobe, and a preload port
    always @(posedge clk) begin
        if (preload) regMem[preAddr] <= preData;
        else if (reg_we) regMem[reg_addr] <= reg_wdata;
        if (reg_rd) reg_rdata <= regMem[reg_addr];
    end

    // Monitor that counts strobes and records which byte spioe was seen in
    always @(negedge clk) begin
        if (reg_we) begin
            weCount = weCount + 1;
            weAddr  = reg_addr;
            weData  = reg_wdata;
        end
        if (reg_rd) begin
            rdCount = rdCount + 1;
            rdAddr  = reg_addr;
        end
        if (spioe && byteIdx == 1) spioeB1 = 1'b1;
        if (spioe && byteIdx == 2) spioeB2 = 1'b1;
        if (spioe && byteIdx == 0) spioeOut = 1'b1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_miso"},  16'(miso),      16'h0);
        check({tag, "_spioe"}, 16'(spioe),     16'h0);
        check({tag, "_addr"},  16'(reg_addr),  16'h0);
        check({tag, "_wdata"}, 16'(reg_wdata), 16'h0);
        check({tag, "_we"},    16'(reg_we),    16'h0);
        check({tag, "_rd"},    16'(reg_rd),    16'h0);
        check({tag, "_busy"},  16'(busy),      16'h0);
    endtask

    task automatic preloadReg(input logic [3:0] a, input logic [7:0] d);
        preAddr = a;
        preData = d;
        preload = 1'b1;
        waitCycles(1);
        preload = 1'b0;
        expMem[a] = d;
    endtask

    // One ss window with nRises sclk rises. Bits past 16 are random, and the master
    // samples miso on rises 9..16. When resetAt > 0, rstn is pulsed after that rise.
    task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] dat, input int nRises,
                                 input int resetAt, output logic [7:0] rdByte, output bit busyOk);
        logic [15:0] bits;
        int half;
        bits    = {cmd, dat};
        rdByte  = 8'h00;
        busyOk  = 1'b0;
        weCount = 0;
        rdCount = 0;
        spioeB1 = 1'b0;
        spioeB2 = 1'b0;
        byteIdx = 1;
        ss = 1'b1;
        waitCycles(5);
        for (int i = 0; i < nRises; i++) begin
            half = $urandom_range(6, 9);
            sclk = 1'b0;
            mosi = (i < 16) ? bits[15 - i] : 1'($urandom);
            waitCycles(half);
            if (i >= 8 && i < 16) rdByte = {rdByte[6:0], misoPad};
            sclk = 1'b1;
            if (i == 7) byteIdx = 2;
            if (i + 1 == resetAt) begin
                waitCycles(3);
                rstn = 1'b0;
                #1;
                checkResetOutputs("midrst");
                ss = 1'b0;
                byteIdx = 0;
                waitCycles(4);
                rstn = 1'b1;
                waitCycles(4);
                busyOk = 1'b1;
                return;
            end
            waitCycles(half);
        end
        waitCycles(5);
        ss = 1'b0;
        for (int k = 0; k < 4; k++) begin
            waitCycles(1);
            if (!busy) begin
                busyOk = 1'b1;
                break;
            end
        end
        waitCycles(2);
        byteIdx = 0;
        waitCycles(5);
    endtask

    // Frame-level model: writes need all 16 rises, reads strobe after 8 and return data after 16
    task automatic checkOutput(input string tag, input logic [7:0] cmd, input logic [7:0] dat,
                               input int nRises, input logic [7:0] rdByte, input bit busyOk);
        bit rw;
        logic [3:0] addr;
        int expWe;
        int expRd;
        rw    = cmd[7];
        addr  = cmd[6:3];
        expWe = (!rw && nRises >= 16) ? 1 : 0;
        expRd = (rw && nRises >= 8) ? 1 : 0;
        check({tag, "_weCount"}, 16'(weCount), 16'(expWe));
        check({tag, "_rdCount"}, 16'(rdCount), 16'(expRd));
        if (expWe == 1) begin
            check({tag, "_weAddr"}, 16'(weAddr), 16'(addr));
            check({tag, "_weData"}, 16'(weData), 16'(dat));
            expMem[addr] = dat;
        end
        if (expRd == 1) check({tag, "_rdAddr"}, 16'(rdAddr), 16'(addr));
        if (rw && nRises >= 16) check({tag, "_rdByte"}, 16'(rdByte), 16'(expMem[addr]));
        check({tag, "_spioeB1"}, 16'(spioeB1), 16'h0);
        check({tag, "_spioeB2"}, 16'(spioeB2), 16'(expRd));
        check({tag, "_spioeOut"}, 16'(spioeOut), 16'h0);
        check({tag, "_busyFall"}, 16'(busyOk), 16'h1);
    endtask

    initial begin
        logic [7:0] rdByte;
        bit         busyOk;
        logic [7:0] cmd;
        logic [7:0] dat;
        int         nRises;
        int         sel;

        rstn = 1'b0;
        ss   = 1'b0;
        sclk = 1'b1;
        mosi = 1'b0;
        waitCycles(3);
        checkResetOutputs("reset");
        rstn = 1'b1;
        waitCycles(3);

        for (int i = 0; i < 16; i++) preloadReg(4'(i), 8'($urandom));

        $display("[TB] write 0xe <- 0x10");
        applyStimulus(8'h70, 8'h10, 16, -1, rdByte, busyOk);
        checkOutput("wr_e", 8'h70, 8'h10, 16, rdByte, busyOk);

        $display("[TB] read 0xd returning 0xA5");
        preloadReg(4'hd, 8'hA5);
        applyStimulus(8'hE8, 8'h00, 16, -1, rdByte, busyOk);
        checkOutput("rd_d", 8'hE8, 8'h00, 16, rdByte, busyOk);
        check("rd_d_A5", 16'(rdByte), 16'h00A5);

        $display("[TB] back-to-back write/read of 0xf");
        applyStimulus(8'h78, 8'h01, 16, -1, rdByte, busyOk);
        checkOutput("wr_f", 8'h78, 8'h01, 16, rdByte, busyOk);
        applyStimulus(8'hF8, 8'h00, 16, -1, rdByte, busyOk);
        checkOutput("rd_f", 8'hF8, 8'h00, 16, rdByte, busyOk);
        check("rd_f_01", 16'(rdByte), 16'h0001);

        $display("[TB] write aborted after 12 rises, then a full write");
        applyStimulus(8'h10, 8'h3C, 12, -1, rdByte, busyOk);
        checkOutput("abort", 8'h10, 8'h3C, 12, rdByte, busyOk);
        applyStimulus(8'h10, 8'hC3, 16, -1, rdByte, busyOk);
        checkOutput("after_abort", 8'h10, 8'hC3, 16, rdByte, busyOk);

        $display("[TB] write with 20 rises");
        applyStimulus(8'h70, 8'h5A, 20, -1, rdByte, busyOk);
        checkOutput("rises20", 8'h70, 8'h5A, 20, rdByte, busyOk);

        $display("[TB] reset during byte 2 of a read");
        applyStimulus(8'hE8, 8'h00, 16, 12, rdByte, busyOk);
        check("midrst_rdCount", 16'(rdCount), 16'h1);
        check("midrst_weCount", 16'(weCount), 16'h0);
        applyStimulus(8'hE8, 8'h00, 16, -1, rdByte, busyOk);
        checkOutput("post_rst", 8'hE8, 8'h00, 16, rdByte, busyOk);

        $display("[TB] random frames");
        for (int f = 0; f < 12; f++) begin
            cmd = {1'($urandom), 4'($urandom), 3'($urandom)};
            dat = 8'($urandom);
            sel = $urandom_range(0, 3);
            if (sel <= 1) nRises = 16;
            else if (sel == 2) nRises = $urandom_range(17, 20);
            else nRises = $urandom_range(1, 15);
            applyStimulus(cmd, dat, nRises, -1, rdByte, busyOk);
            checkOutput($sformatf("rand%0d", f), cmd, dat, nRises, rdByte, busyOk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
